matrix_walk_ctrl: RTL and testbench

Sequencer that walks a ROWS×COLS matrix index space and streams (row, col) coordinates to downstream memory/datapath stages under valid/ready flow control. It runs in full mode (every element) or triangular mode (lower triangle including diagonal, for symmetric covariance/correlation matrices in the LCMV pipeline). The controller sits between the top-level phase FSM (start/done) and the matrix buffer address ports.

---
 rtl/matrix_walk_pkg.sv | 10 +
 rtl/matrix_walk_ctrl_counter.sv | 21 ++
 rtl/matrix_walk_ctrl.sv | 99 +++++++++
 tb/tb_matrix_walk_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_walk_pkg.sv
// Shared types for the matrix walk sequencer.
package matrix_walk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/matrix_walk_ctrl_counter.sv
// Modulo-MOD up counter with a synchronous clear that has priority over counting.
module counter_mod #(
    parameter  int unsigned MOD = 16,
    localparam int unsigned W   = (MOD > 1) ? $clog2(MOD) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         up,
    input  logic         reset_count,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || reset_count) begin
            count <= '0;
        end else if (up) begin
            count <= (count == W'(MOD - 1)) ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/matrix_walk_ctrl.sv
// Streams (row, col) coordinates of a full or lower-triangular matrix walk
// under valid/ready flow control.
module matrix_walk_ctrl
    import matrix_walk_pkg::*;
#(
    parameter  int unsigned ROWS  = 16,
    parameter  int unsigned COLS  = 16,
    localparam int unsigned ROW_W = $clog2(ROWS),
    localparam int unsigned COL_W = $clog2(COLS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             tri_mode,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             row_last,
    output logic             mat_last,
    output logic             busy,
    output logic             done
);

    localparam int unsigned IDX_W = (ROW_W > COL_W) ? ROW_W : COL_W;

    state_t state;
    logic   tri_mode_q;
    logic   fire;
    logic   clear;
    logic   on_diag;
    logic   col_end;

    assign fire    = out_valid && out_ready;
    assign clear   = (state == IDLE) && start;
    assign on_diag = (IDX_W'(col) == IDX_W'(row));
    assign col_end = tri_mode_q ? on_diag : (col == COL_W'(COLS - 1));

    // Last-flags decode purely from registered state and indices.
    assign row_last = (state == RUN) && col_end;
    assign mat_last = row_last && (row == ROW_W'(ROWS - 1));

    // In full mode the column wraps at COLS-1 by itself; tri mode wraps on the diagonal.
    counter_mod #(.MOD(COLS)) u_col_cnt (
        .clk         (clk),
        .rst         (rst),
        .up          (fire),
        .reset_count (clear || (fire && tri_mode_q && on_diag)),
        .count       (col)
    );

    // The row counter wraps to 0 on the final fire, leaving indices clean for the next walk.
    counter_mod #(.MOD(ROWS)) u_row_cnt (
        .clk         (clk),
        .rst         (rst),
        .up          (fire && row_last),
        .reset_count (clear),
        .count       (row)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            tri_mode_q <= 1'b0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= RUN;
                        tri_mode_q <= tri_mode;
                        out_valid  <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                RUN: begin
                    if (fire && mat_last) begin
                        state     <= DONE;
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_walk_ctrl.sv
// Scoreboard bench for matrix_walk_ctrl with a 4x4 index space.
module tb_matrix_walk_ctrl;

    localparam int unsigned ROWS = 4;
    localparam int unsigned COLS = 4;

    logic       clk;
    logic       rst;
    logic       start;
    logic       tri_mode;
    logic       out_ready;
    logic       out_valid;
    logic [1:0] row;
    logic [1:0] col;
    logic       row_last;
    logic       mat_last;
    logic       busy;
    logic       done;

    typedef struct {
        int r;
        int c;
        int rl;
        int ml;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   done_seen = 0;
    int   done_exp  = 0;

    matrix_walk_ctrl #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .tri_mode  (tri_mode),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .row       (row),
        .col       (col),
        .row_last  (row_last),
        .mat_last  (mat_last),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected coordinate stream of one walk, row-major.
    task automatic push_walk(input bit tri_w);
        for (int r = 0; r < int'(ROWS); r++) begin
            int lastc;
            lastc = tri_w ? r : int'(COLS) - 1;
            for (int c = 0; c <= lastc; c++) begin
                exp_t e;
                e.r  = r;
                e.c  = c;
                e.rl = (c == lastc) ? 1 : 0;
                e.ml = (c == lastc && r == int'(ROWS) - 1) ? 1 : 0;
                sb.push_back(e);
            end
        end
        done_exp++;
    endtask

    // Monitor: pops on every transfer, also checks stability under backpressure.
    logic       stalled;
    logic [1:0] s_row;
    logic [1:0] s_col;
    logic       s_rl;
    logic       s_ml;
    initial stalled = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (done) done_seen++;
            if (stalled) begin
                chk("hold_valid", int'(out_valid), 1);
                chk("hold_row", int'(row), int'(s_row));
                chk("hold_col", int'(col), int'(s_col));
                chk("hold_flags", int'({row_last, mat_last}), int'({s_rl, s_ml}));
            end
            stalled = out_valid && !out_ready;
            s_row = row; s_col = col; s_rl = row_last; s_ml = mat_last;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_xfer", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("row", int'(row), e.r);
                    chk("col", int'(col), e.c);
                    chk("row_last", int'(row_last), e.rl);
                    chk("mat_last", int'(mat_last), e.ml);
                end
            end
        end
    end

    // Runs one walk from the cycle after the start edge; cycle i is sampled on negedge i.
    task automatic walk(input int exp_done_cyc, input int stall_lo, input int stall_hi,
                        input int poke_cyc, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 1; i <= 60 && !seen; i++) begin
            out_ready = !(i >= stall_lo && i <= stall_hi);
            if (poke_cyc > 0) begin
                start = (i == poke_cyc);
                if (i == poke_cyc) tri_mode = ~tri_mode;
            end
            @(negedge clk);
            if (i == 1) chk({name, "_first_valid"}, int'(out_valid), 1);
            if (done) begin
                seen = 1'b1;
                chk({name, "_done_cycle"}, i, exp_done_cyc);
                chk({name, "_done_busy"}, int'(busy), 1);
            end
            @(posedge clk);
            #1;
        end
        if (!seen) chk({name, "_done_timeout"}, 0, 1);
        out_ready = 1'b1;
        @(negedge clk);
        chk({name, "_idle_busy"}, int'(busy), 0);
        chk({name, "_idle_valid"}, int'(out_valid), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic kick(input bit tri_w);
        start    = 1'b1;
        tri_mode = tri_w;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; tri_mode = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_idx", int'({row, col}), 0);
        chk("rst_flags", int'({row_last, mat_last}), 0);
        @(posedge clk);
        #1;

        // Full walk
        push_walk(1'b0);
        kick(1'b0);
        walk(17, 0, -1, 0, "full");

        // Lower-triangular walk
        push_walk(1'b1);
        kick(1'b1);
        walk(11, 0, -1, 0, "tri");

        // Backpressure on cycles 3..5
        push_walk(1'b0);
        kick(1'b0);
        walk(20, 3, 5, 0, "bp");

        // start and tri_mode poked mid-walk are ignored
        push_walk(1'b0);
        kick(1'b0);
        walk(17, 0, -1, 5, "ignore");
        start = 1'b0;

        // Reset on the 7th transfer
        push_walk(1'b0);
        done_exp--;
        kick(1'b0);
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_idx", int'({row, col}), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_left", sb.size(), 10);
        sb.delete();
        @(posedge clk);
        #1;
        push_walk(1'b0);
        kick(1'b0);
        walk(17, 0, -1, 0, "after_rst");

        // start held high: done, one IDLE cycle, then a new walk
        push_walk(1'b0);
        push_walk(1'b0);
        start    = 1'b1;
        tri_mode = 1'b0;
        @(posedge clk);
        #1;
        walk(17, 0, -1, 0, "b2b_a");
        start = 1'b0;
        walk(17, 0, -1, 0, "b2b_b");

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        chk("done_pulses", done_seen, done_exp);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
